// File: rtl/multich_vec_sequencer.sv
// Multi-channel vector sequencer: fetches allocation instructions and streams data/coef RAM
// addresses per vector, replaying the program once per channel. Define DATA_WRAP_EN for circular data addressing.
module multich_vec_sequencer #(
  parameter int VEC_ID_WIDTH       = 4,
  parameter int REGFILE_ADDR_WIDTH = 4,
  parameter int ALLOC_LENGTH_WIDTH = 8,
  parameter int DATA_ADDR_WIDTH    = 10,
  parameter int INSTR_ADDR_WIDTH   = 6,
  parameter int CHANNELS           = 2,
  parameter int CH_STRIDE          = 64,
  parameter int UPS_FACTOR         = 2,
  localparam int IW = 2 + VEC_ID_WIDTH + 2*REGFILE_ADDR_WIDTH + ALLOC_LENGTH_WIDTH + 2*DATA_ADDR_WIDTH,
  localparam int CH_WIDTH = $clog2(CHANNELS) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          prog,
  input  logic [IW-1:0]                 instr_word,
  output logic                          fetch,
  output logic [INSTR_ADDR_WIDTH-1:0]   pc,
  output logic [CH_WIDTH-1:0]           ch,
  output logic                          en_ram_pa,
  output logic                          wr_ram_pa,
  output logic                          en_ram_pb,
  output logic                          wr_ram_pb,
  output logic [DATA_ADDR_WIDTH-1:0]    data_addr,
  output logic [DATA_ADDR_WIDTH-1:0]    coef_addr,
  output logic                          rw,
  output logic [REGFILE_ADDR_WIDTH-1:0] ar1,
  output logic [REGFILE_ADDR_WIDTH-1:0] ar2,
  output logic [REGFILE_ADDR_WIDTH-1:0] ard,
  output logic                          done
);

  typedef enum logic [2:0] {
    S0_IDLE    = 3'd0,
    S1_FETCH   = 3'd1,
    S2_DECODE  = 3'd2,
    S3_RUN     = 3'd3,
    S4_WB      = 3'd4,
    S5_STORE   = 3'd5,
    S6_NEXT_CH = 3'd6,
    S7_DONE    = 3'd7
  } state_e;

  typedef struct packed {
    logic                          lstg_f;
    logic                          upse_f;
    logic [VEC_ID_WIDTH-1:0]       vector_id;
    logic [REGFILE_ADDR_WIDTH-1:0] result_reg;
    logic [REGFILE_ADDR_WIDTH-1:0] error_reg;
    logic [ALLOC_LENGTH_WIDTH-1:0] vector_len;
    logic [DATA_ADDR_WIDTH-1:0]    data_ptr;
    logic [DATA_ADDR_WIDTH-1:0]    coef_ptr;
  } instr_t;

  state_e                        state_q, state_n;
  instr_t                        instr;
  logic                          lstg_q;
  logic [ALLOC_LENGTH_WIDTH-1:0] len_q;
  logic [ALLOC_LENGTH_WIDTH-1:0] idx_q;
  logic [DATA_ADDR_WIDTH-1:0]    base_q;
  logic [DATA_ADDR_WIDTH-1:0]    step_q;
  logic [DATA_ADDR_WIDTH-1:0]    ch_base_q;
  logic [DATA_ADDR_WIDTH-1:0]    base_now;
  logic [DATA_ADDR_WIDTH-1:0]    addr_first;
  logic [DATA_ADDR_WIDTH-1:0]    addr_next;
  logic                          last_idx;
  logic                          last_stage;
  logic                          last_ch;
  logic                          unused_vec_id;

`ifdef DATA_WRAP_EN
  logic [ALLOC_LENGTH_WIDTH-1:0] frame_q;
  logic [ALLOC_LENGTH_WIDTH-1:0] off_q;
  logic [ALLOC_LENGTH_WIDTH-1:0] off_first;
  logic [ALLOC_LENGTH_WIDTH-1:0] off_next;
`endif

  assign instr         = instr_t'(instr_word);
  assign unused_vec_id = ^instr.vector_id;
  assign last_idx      = (idx_q == len_q - 1'b1);
  // The top program slot never wraps pc: it always closes the channel pass.
  assign last_stage    = lstg_q | (pc == '1);
  assign last_ch       = (ch == CH_WIDTH'(CHANNELS - 1));
  assign wr_ram_pb     = 1'b0;

  // Data addresses: first index is formed from the raw instruction word at decode,
  // later indices step from the latched channel base.
  always_comb begin
    base_now = instr.data_ptr + ch_base_q;
`ifdef DATA_WRAP_EN
    off_first  = frame_q & (instr.vector_len - 1'b1);
    off_next   = (off_q + 1'b1) & (len_q - 1'b1);
    addr_first = base_now + DATA_ADDR_WIDTH'(off_first);
    addr_next  = base_q + DATA_ADDR_WIDTH'(off_next);
`else
    addr_first = base_now;
    addr_next  = data_addr + 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S0_IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n   = state_q;
    fetch     = 1'b0;
    en_ram_pa = 1'b0;
    wr_ram_pa = 1'b0;
    en_ram_pb = 1'b0;
    rw        = 1'b0;
    done      = 1'b0;
    if (prog) begin
      state_n = S0_IDLE;
    end else if (en) begin
      unique case (state_q)
        S0_IDLE:    state_n = S1_FETCH;
        S1_FETCH:   state_n = S2_DECODE;
        S2_DECODE:  state_n = (instr.vector_len == '0) ? S4_WB : S3_RUN;
        S3_RUN:     if (last_idx) state_n = S4_WB;
        S4_WB:      state_n = last_stage ? S5_STORE : S1_FETCH;
        S5_STORE:   state_n = last_ch ? S7_DONE : S6_NEXT_CH;
        S6_NEXT_CH: state_n = S1_FETCH;
        S7_DONE:    state_n = S1_FETCH;
        default:    state_n = S0_IDLE;
      endcase
    end
    if (en) begin
      unique case (state_q)
        S1_FETCH: fetch = 1'b1;
        S3_RUN: begin
          en_ram_pa = 1'b1;
          en_ram_pb = 1'b1;
        end
        S4_WB:    rw = 1'b1;
        S5_STORE: begin
          en_ram_pa = 1'b1;
          wr_ram_pa = 1'b1;
        end
        S7_DONE:  done = 1'b1;
        default:  ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= '0;
      ch        <= '0;
      ch_base_q <= '0;
      data_addr <= '0;
      coef_addr <= '0;
      ar1       <= '0;
      ar2       <= '0;
      ard       <= '0;
      lstg_q    <= 1'b0;
      len_q     <= '0;
      idx_q     <= '0;
      base_q    <= '0;
      step_q    <= '0;
`ifdef DATA_WRAP_EN
      frame_q   <= '0;
      off_q     <= '0;
`endif
    end else if (prog) begin
      pc        <= '0;
      ch        <= '0;
      ch_base_q <= '0;
    end else if (en) begin
      unique case (state_q)
        S2_DECODE: begin
          lstg_q    <= instr.lstg_f;
          len_q     <= instr.vector_len;
          idx_q     <= '0;
          base_q    <= base_now;
          data_addr <= addr_first;
          coef_addr <= instr.coef_ptr;
          step_q    <= instr.upse_f ? DATA_ADDR_WIDTH'(UPS_FACTOR) : DATA_ADDR_WIDTH'(1);
          ar1       <= instr.result_reg;
          ar2       <= instr.error_reg;
          ard       <= instr.result_reg;
`ifdef DATA_WRAP_EN
          off_q     <= off_first;
`endif
        end
        S3_RUN: begin
          if (!last_idx) begin
            idx_q     <= idx_q + 1'b1;
            data_addr <= addr_next;
            coef_addr <= coef_addr + step_q;
`ifdef DATA_WRAP_EN
            off_q     <= off_next;
`endif
          end
        end
        S4_WB: begin
          if (last_stage) data_addr <= base_q;
          else            pc <= pc + 1'b1;
        end
        S6_NEXT_CH: begin
          ch        <= ch + 1'b1;
          ch_base_q <= ch_base_q + DATA_ADDR_WIDTH'(CH_STRIDE);
          pc        <= '0;
        end
        S7_DONE: begin
          ch        <= '0;
          ch_base_q <= '0;
          pc        <= '0;
`ifdef DATA_WRAP_EN
          frame_q   <= frame_q + 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multich_vec_sequencer.sv
// Bench for multich_vec_sequencer: a per-cycle vector table, hand sequences for reset/prog/en corners,
// and random programs checked against a program-level trace model.
`timescale 1ns/1ps
module tb_multich_vec_sequencer;
  localparam int VW = 4, RW = 4, LW = 8, DW = 10, PW = 6, NCH = 2, STRIDE = 64, UPS = 2;
  localparam int IW = 2 + VW + 2*RW + LW + 2*DW;
  localparam int CW = $clog2(NCH) + 1;
  // strobe order: fetch, en_ram_pa, wr_ram_pa, en_ram_pb, wr_ram_pb, rw, done
  localparam logic [6:0] ST_IDLE  = 7'b0000000;
  localparam logic [6:0] ST_FETCH = 7'b1000000;
  localparam logic [6:0] ST_RUN   = 7'b0101000;
  localparam logic [6:0] ST_STORE = 7'b0110000;
  localparam logic [6:0] ST_WB    = 7'b0000010;
  localparam logic [6:0] ST_DONE  = 7'b0000001;

  logic          clk = 1'b0, rst = 1'b1, en = 1'b0, prog = 1'b0;
  logic [IW-1:0] instr_word = '0;
  logic          fetch, en_ram_pa, wr_ram_pa, en_ram_pb, wr_ram_pb, rw, done;
  logic [PW-1:0] pc;
  logic [CW-1:0] ch;
  logic [DW-1:0] data_addr, coef_addr;
  logic [RW-1:0] ar1, ar2, ard;
  logic [6:0]    strb;

  multich_vec_sequencer #(
    .VEC_ID_WIDTH(VW), .REGFILE_ADDR_WIDTH(RW), .ALLOC_LENGTH_WIDTH(LW), .DATA_ADDR_WIDTH(DW),
    .INSTR_ADDR_WIDTH(PW), .CHANNELS(NCH), .CH_STRIDE(STRIDE), .UPS_FACTOR(UPS)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .prog(prog), .instr_word(instr_word),
    .fetch(fetch), .pc(pc), .ch(ch),
    .en_ram_pa(en_ram_pa), .wr_ram_pa(wr_ram_pa), .en_ram_pb(en_ram_pb), .wr_ram_pb(wr_ram_pb),
    .data_addr(data_addr), .coef_addr(coef_addr), .rw(rw),
    .ar1(ar1), .ar2(ar2), .ard(ard), .done(done)
  );

  always #5 clk = ~clk;

  logic [IW-1:0] rom [64];
  always @(posedge clk) if (fetch) instr_word <= rom[pc];

  assign strb = {fetch, en_ram_pa, wr_ram_pa, en_ram_pb, wr_ram_pb, rw, done};

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  typedef struct {
    bit lstg;
    bit upse;
    int vid, res, err, len, dp, cp;
  } instr_t;

  typedef struct {
    logic [6:0] strb;
    int pc, ch, daddr, caddr, ar, arb;
  } exp_t;

  typedef struct {
    logic       en;
    logic [6:0] strb;
    int         daddr, caddr;
  } vec_t;

  instr_t pgm [64];
  int     pgm_n;
  exp_t   exp_q [$];
  int     model_frame;
  vec_t   tbl [19];

  function automatic logic [IW-1:0] pack_instr(instr_t x);
    return {x.lstg, x.upse, VW'(x.vid), RW'(x.res), RW'(x.err), LW'(x.len), DW'(x.dp), DW'(x.cp)};
  endfunction

  function automatic instr_t mk(bit lstg, bit upse, int res, int err, int len, int dp, int cp);
    instr_t x;
    x = '{lstg, upse, 0, res, err, len, dp, cp};
    return x;
  endfunction

  // Slots past the program end are terminating empty instructions in both ROM and model.
  task automatic load_rom();
    for (int i = 0; i < 64; i++) begin
      if (i >= pgm_n) pgm[i] = mk(1'b1, 1'b0, 0, 0, 0, 0, 0);
      rom[i] = pack_instr(pgm[i]);
    end
  endtask

  function automatic exp_t rec(logic [6:0] s);
    exp_t r;
    r = '{s, -1, -1, -1, -1, -1, -1};
    return r;
  endfunction

  // Expected trace of enabled cycles: frames x channels x program walk.
  task automatic build_expected(input int frames, input bit from_idle);
    exp_t   r;
    instr_t x;
    int     pcv, off;
    exp_q.delete();
    if (from_idle) exp_q.push_back(rec(ST_IDLE));
    for (int f = 0; f < frames; f++) begin
      for (int c = 0; c < NCH; c++) begin
        pcv = 0;
        forever begin
          x = pgm[pcv];
          r = rec(ST_FETCH); r.pc = pcv; r.ch = c; exp_q.push_back(r);
          exp_q.push_back(rec(ST_IDLE));
          for (int i = 0; i < x.len; i++) begin
`ifdef DATA_WRAP_EN
            off = (model_frame + i) & (x.len - 1);
`else
            off = i;
`endif
            r = rec(ST_RUN);
            r.daddr = (x.dp + c*STRIDE + off) % (1 << DW);
            r.caddr = (x.cp + i*(x.upse ? UPS : 1)) % (1 << DW);
            exp_q.push_back(r);
          end
          r = rec(ST_WB); r.ch = c; r.ar = x.res; r.arb = x.err; exp_q.push_back(r);
          if (x.lstg || pcv == (1 << PW) - 1) begin
            r = rec(ST_STORE); r.daddr = (x.dp + c*STRIDE) % (1 << DW); exp_q.push_back(r);
            break;
          end
          pcv++;
        end
        exp_q.push_back(rec(c < NCH - 1 ? ST_IDLE : ST_DONE));
      end
      model_frame++;
    end
  endtask

  task automatic compare_rec(input int k);
    exp_t e;
    e = exp_q[k];
    check($sformatf("strobes[%0d]", k), 32'(strb), 32'(e.strb));
    if (e.pc >= 0)    check($sformatf("pc[%0d]", k), 32'(pc), e.pc);
    if (e.ch >= 0)    check($sformatf("ch[%0d]", k), 32'(ch), e.ch);
    if (e.daddr >= 0) check($sformatf("data_addr[%0d]", k), 32'(data_addr), e.daddr);
    if (e.caddr >= 0) check($sformatf("coef_addr[%0d]", k), 32'(coef_addr), e.caddr);
    if (e.ar >= 0) begin
      check($sformatf("ar1[%0d]", k), 32'(ar1), e.ar);
      check($sformatf("ard[%0d]", k), 32'(ard), e.ar);
      check($sformatf("ar2[%0d]", k), 32'(ar2), e.arb);
    end
  endtask

  // Caller sits just after a rising edge; en=0 cycles must show no strobes and consume no trace entry.
  task automatic run_expected(input int start, input bit rand_en);
    int k, budget;
    k = start;
    budget = 0;
    while (k < exp_q.size() && budget < 20000) begin
      en = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (en) begin
        compare_rec(k);
        k++;
      end else begin
        check("strobes_en_low", 32'(strb), 32'(ST_IDLE));
      end
      @(posedge clk); #1;
      budget++;
    end
    check("trace_complete", k, exp_q.size());
    en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; prog = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_frame = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Cycle table for {lstg=1,len=4,data_ptr=16,coef_ptr=32} over two channels.
    tbl[0] = '{1'b1, ST_IDLE, -1, -1};
    tbl[1] = '{1'b1, ST_FETCH, -1, -1};
    tbl[2] = '{1'b1, ST_IDLE, -1, -1};
    for (int i = 0; i < 4; i++) tbl[3 + i] = '{1'b1, ST_RUN, 16 + i, 32 + i};
    tbl[7]  = '{1'b1, ST_WB, -1, -1};
    tbl[8]  = '{1'b1, ST_STORE, 16, -1};
    tbl[9]  = '{1'b1, ST_IDLE, -1, -1};
    tbl[10] = '{1'b1, ST_FETCH, -1, -1};
    tbl[11] = '{1'b1, ST_IDLE, -1, -1};
    for (int i = 0; i < 4; i++) tbl[12 + i] = '{1'b1, ST_RUN, 16 + STRIDE + i, 32 + i};
    tbl[16] = '{1'b1, ST_WB, -1, -1};
    tbl[17] = '{1'b1, ST_STORE, 16 + STRIDE, -1};
    tbl[18] = '{1'b1, ST_DONE, -1, -1};

    // Reset state.
    do_reset();
    @(negedge clk);
    check("rst_strobes", 32'(strb), 32'(ST_IDLE));
    check("rst_pc", 32'(pc), 0);
    check("rst_ch", 32'(ch), 0);
    @(posedge clk); #1;

    // Table-driven single-instruction program.
    pgm_n = 1; pgm[0] = mk(1'b1, 1'b0, 3, 4, 4, 16, 32); load_rom();
    do_reset();
    for (int i = 0; i < 19; i++) begin
      en = tbl[i].en;
      @(negedge clk);
      check($sformatf("tbl_strobes[%0d]", i), 32'(strb), 32'(tbl[i].strb));
      if (tbl[i].daddr >= 0) check($sformatf("tbl_data[%0d]", i), 32'(data_addr), tbl[i].daddr);
      if (tbl[i].caddr >= 0) check($sformatf("tbl_coef[%0d]", i), 32'(coef_addr), tbl[i].caddr);
      @(posedge clk); #1;
    end
    en = 1'b0;

    // Reset mid-RUN of the second instruction.
    pgm_n = 2; pgm[0] = mk(1'b0, 1'b0, 7, 8, 1, 40, 50); pgm[1] = mk(1'b1, 1'b0, 9, 2, 6, 5, 7);
    load_rom();
    do_reset();
    en = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    @(negedge clk);
    check("pre_rst_run", 32'(strb), 32'(ST_RUN));
    check("pre_rst_pc", 32'(pc), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_strobes", 32'(strb), 32'(ST_IDLE));
    check("mid_rst_pc", 32'(pc), 0);
    check("mid_rst_data", 32'(data_addr), 0);
    check("mid_rst_coef", 32'(coef_addr), 0);
    check("mid_rst_ar1", 32'(ar1), 0);
    check("mid_rst_ar2", 32'(ar2), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_frame = 0;
    build_expected(1, 1'b1);
    run_expected(0, 1'b0);

    // prog during FETCH of pc=1 returns to idle and restarts from pc 0.
    do_reset();
    en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("pre_prog_fetch_pc", 32'(pc), 1);
    prog = 1'b1;
    @(posedge clk); #1;
    check("prog_strobes", 32'(strb), 32'(ST_IDLE));
    check("prog_pc", 32'(pc), 0);
    check("prog_ch", 32'(ch), 0);
    prog = 1'b0;
    build_expected(1, 1'b1);
    run_expected(0, 1'b0);

    // Upsampled coefficient stride.
    pgm_n = 1; pgm[0] = mk(1'b1, 1'b1, 1, 2, 3, 0, 10); load_rom();
    do_reset();
    build_expected(1, 1'b1);
    check("ups_model_c2", exp_q[5].caddr, 14);
    run_expected(0, 1'b0);

    // en dropped for two cycles at RUN index 1.
    pgm_n = 1; pgm[0] = mk(1'b1, 1'b0, 3, 5, 4, 100, 200); load_rom();
    do_reset();
    build_expected(1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      en = 1'b1;
      @(negedge clk);
      compare_rec(k);
      @(posedge clk); #1;
    end
    for (int j = 0; j < 2; j++) begin
      en = 1'b0;
      @(negedge clk);
      check("hold_strobes", 32'(strb), 32'(ST_IDLE));
      check("hold_data", 32'(data_addr), 101);
      check("hold_coef", 32'(coef_addr), 201);
      @(posedge clk); #1;
    end
    run_expected(4, 1'b0);

    // Empty vector followed by a multi-frame run (circular offsets when wrap is built in).
    pgm_n = 2; pgm[0] = mk(1'b0, 1'b0, 2, 3, 0, 500, 600); pgm[1] = mk(1'b1, 1'b0, 4, 6, 4, 0, 0);
    load_rom();
    do_reset();
    build_expected(4, 1'b1);
    run_expected(0, 1'b0);

    // Full ROM without a last-stage flag: the top slot ends the pass.
    pgm_n = 64;
    for (int i = 0; i < 64; i++) pgm[i] = mk(1'b0, 1'b0, i % 16, (i + 3) % 16, 0, i * 7, i);
    load_rom();
    do_reset();
    build_expected(1, 1'b1);
    run_expected(0, 1'b0);

    // Random programs with random enable gaps.
    for (int t = 0; t < 8; t++) begin
`ifdef DATA_WRAP_EN
      int lens [5] = '{0, 1, 2, 4, 8};
`endif
      pgm_n = $urandom_range(1, 4);
      for (int i = 0; i < pgm_n; i++) begin
        pgm[i] = mk(($urandom_range(0, 4) == 0) || (i == pgm_n - 1), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 15), $urandom_range(0, 15), 0,
                    $urandom_range(0, 1023), $urandom_range(0, 1023));
`ifdef DATA_WRAP_EN
        pgm[i].len = lens[$urandom_range(0, 4)];
`else
        pgm[i].len = $urandom_range(0, 6);
`endif
      end
      load_rom();
      do_reset();
      build_expected(2, 1'b1);
      run_expected(0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
